slavefifo2b_mode_ctrl: RTL and testbench
========================================

Name: slavefifo2b_mode_ctrl

Overview:
- Sequences and arbitrates the FX3 slave-FIFO 2-bit bus between the per-mode traffic generators: loopback, stream-IN, stream-OUT and ZLP.
- Takes a mode request, deselects the old generator, drains it, inserts a bus-quiet guard interval, then grants exactly one generator.
- Muxes the granted generator's strobes, address and data onto the FX3 pins.
- Also registers the raw FX3 flags into the flaga_d..flagd_d copies the generators consume.

Parameters:
- NMODES, 4, number of generator requesters; mode code k (1..NMODES) maps to requester index k-1.
- DW, 32, FIFO data width.
- GUARD_CYC, 4, idle cycles with all strobes deasserted between deselect-done and new grant; legal range 1..15.
- DRAIN_MAX, 255, drain timeout in cycles before a forced switch.

Ports:
- clk_100  in  1  100 MHz FIFO clock
- reset_  in  1  reset, asynchronous, active-low
- mode_req  in  3  requested mode code; 0 = none; codes greater than NMODES are treated as 0; quasi-static, may be asynchronous
- flaga, flagb, flagc, flagd  in  1 each  raw FX3 flags
- flaga_d, flagb_d, flagc_d, flagd_d  out  1 each  flags registered once
- mode_sel  out  NMODES  one-hot grant ("mode_selected" to each generator); all-zero when none
- req_busy  in  NMODES  generator k is mid-transfer (not in its idle state)
- req_slwr_n, req_slrd_n, req_sloe_n, req_pktend_n  in  NMODES each  per-generator active-low strobes
- req_faddr  in  2*NMODES  per-generator FIFO address
- req_data  in  DW*NMODES  per-generator write data
- slwr_, slrd_, sloe_, pktend_  out  1 each  muxed FX3 strobes
- faddr  out  2  muxed FIFO address
- data_out  out  DW  muxed write data
- data_oe  out  1  drive enable for the bidirectional data pins
- cur_mode  out  3  mode code currently granted (0 if none)
- drain_timeout  out  1  sticky; set on a forced switch, cleared by reset only

Behaviour:
- Reset values:
  - mode_sel = 0, cur_mode = 0, data_oe = 0, faddr = 0, data_out = 0.
  - All strobes = 1.
  - flag*_d = 0, drain_timeout = 0.
  - State = IDLE.
- mode_req passes through a 2-flop synchronizer, then must be stable for 2 further cycles before acting (req_ok).
- States:
  - IDLE: mode_sel = 0. If req_ok and the code is nonzero and differs from cur_mode, go to GUARD with the target latched.
  - ACTIVE: mode_sel = onehot(cur_mode). If req_ok and the code differs from cur_mode, go to DRAIN.
  - DRAIN: mode_sel = 0 and the guard counter is cleared. The deselected generator finishes on its own, and its strobes are still muxed through.
    - Leaves when req_busy[old] = 0 for 2 consecutive cycles.
    - Also leaves if the drain counter reaches DRAIN_MAX; this sets drain_timeout.
    - Target 0 → IDLE (cur_mode = 0). Otherwise → GUARD.
  - GUARD: all strobes forced to 1, data_oe = 0. Counts GUARD_CYC cycles, then ACTIVE with cur_mode = target and mode_sel asserted on the next clock.
- Request changes during DRAIN or GUARD update the latched target. A change to the old mode during DRAIN still completes DRAIN and GUARD; no glitch grant.
- Output mux (registered, 1-cycle latency from req_* to pins):
  - Selects the cur_mode generator in ACTIVE and DRAIN.
  - Strobes = 1 and data_oe = 0 in IDLE and GUARD.
  - data_oe = 1 whenever the muxed slwr_ or pktend_ is low.
- Invariants:
  - mode_sel is never more than one-hot.
  - Strobes from two generators are never merged.
  - At most one of slwr_ and slrd_ is low at a time. If a generator drives both, slrd_ is forced to 1 and slwr_ wins.
- Asserting reset_ mid-transfer immediately forces reset values (asynchronous); the state machine restarts in IDLE.

Decomposition:
- Package slavefifo2b_pkg: mode codes (MODE_NONE=0, LOOPBACK=1, STREAM_IN=2, STREAM_OUT=3, ZLP=4), state encoding, FIFO address constants.
- Sub-module slavefifo2b_sync_stable: synchronizer plus stability filter for mode_req.
- Mux and state machine stay in the top.

Test Plan:
- Reset, then mode_req=4 held: req_ok about 4 cycles later; GUARD for 4 cycles; then mode_sel=4'b1000 and cur_mode=4; the ZLP generator's slwr_=0 appears on the pins 1 cycle later.
- ACTIVE mode 2 with req_busy[1]=1 for 20 cycles, then switch to 3: mode_sel=0 immediately; pins keep following generator 2; grant of 4'b0100 comes 2+4 cycles after busy drops.
- req_busy stuck high with DRAIN_MAX=255, then switch: forced exit 255 cycles after entering DRAIN; drain_timeout=1 and stays set.
- mode_req toggles 2→3→2 within 2 cycles: no switch; cur_mode stays 2.
- mode_req=7 or mode_req=0 while ACTIVE: after DRAIN, goes to IDLE with all strobes 1 and data_oe=0.
- Assert reset_ during a write burst: slwr_=1, mode_sel=0 and flag*_d=0 with no clock edge.

Source files
------------

// File: rtl/slavefifo2b_pkg.sv
// Shared mode codes, state encoding and FIFO address constants for the
// FX3 slave-FIFO 2-bit mode controller.
package slavefifo2b_pkg;

  localparam logic [2:0] MODE_NONE       = 3'd0;
  localparam logic [2:0] MODE_LOOPBACK   = 3'd1;
  localparam logic [2:0] MODE_STREAM_IN  = 3'd2;
  localparam logic [2:0] MODE_STREAM_OUT = 3'd3;
  localparam logic [2:0] MODE_ZLP        = 3'd4;

  localparam logic [1:0] FADDR_IDLE = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_GUARD
  } state_t;

endpackage

// File: rtl/slavefifo2b_sync_stable.sv
// Brings the asynchronous mode request into clk_100 and only reports it once
// the sanitised code has held steady for two cycles after synchronisation.
module slavefifo2b_sync_stable #(
  parameter int NMODES = 4
) (
  input  logic       clk_100,
  input  logic       reset_,
  input  logic [2:0] mode_req,
  output logic [2:0] req_code,
  output logic       req_ok
);

  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic [2:0] hold_q, hold_d;
  logic [1:0] stable_cnt_q, stable_cnt_d;
  logic [2:0] code;

  // Codes beyond the number of generators collapse to "no mode".
  always_comb begin
    meta_d       = mode_req;
    sync_d       = meta_q;
    code         = (sync_q > 3'(NMODES)) ? 3'd0 : sync_q;
    hold_d       = code;
    stable_cnt_d = 2'd0;
    if (code == hold_q) begin
      stable_cnt_d = (stable_cnt_q == 2'd2) ? 2'd2 : stable_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      meta_q       <= 3'd0;
      sync_q       <= 3'd0;
      hold_q       <= 3'd0;
      stable_cnt_q <= 2'd0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      hold_q       <= hold_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign req_code = hold_q;
  assign req_ok   = (stable_cnt_q == 2'd2);

endmodule

// File: rtl/slavefifo2b_mode_ctrl.sv
// Arbitrates the FX3 slave-FIFO bus between the per-mode traffic generators:
// deselect, drain, quiet guard interval, then grant exactly one generator.
module slavefifo2b_mode_ctrl
  import slavefifo2b_pkg::*;
#(
  parameter int NMODES    = 4,
  parameter int DW        = 32,
  parameter int GUARD_CYC = 4,
  parameter int DRAIN_MAX = 255
) (
  input  logic                 clk_100,
  input  logic                 reset_,
  input  logic [2:0]           mode_req,
  input  logic                 flaga,
  input  logic                 flagb,
  input  logic                 flagc,
  input  logic                 flagd,
  output logic                 flaga_d,
  output logic                 flagb_d,
  output logic                 flagc_d,
  output logic                 flagd_d,
  output logic [NMODES-1:0]    mode_sel,
  input  logic [NMODES-1:0]    req_busy,
  input  logic [NMODES-1:0]    req_slwr_n,
  input  logic [NMODES-1:0]    req_slrd_n,
  input  logic [NMODES-1:0]    req_sloe_n,
  input  logic [NMODES-1:0]    req_pktend_n,
  input  logic [2*NMODES-1:0]  req_faddr,
  input  logic [DW*NMODES-1:0] req_data,
  output logic                 slwr_,
  output logic                 slrd_,
  output logic                 sloe_,
  output logic                 pktend_,
  output logic [1:0]           faddr,
  output logic [DW-1:0]        data_out,
  output logic                 data_oe,
  output logic [2:0]           cur_mode,
  output logic                 drain_timeout
);

  localparam int DCW = $clog2(DRAIN_MAX + 1);

  logic [2:0] req_code;
  logic       req_ok;

  slavefifo2b_sync_stable #(.NMODES(NMODES)) u_sync (
    .clk_100  (clk_100),
    .reset_   (reset_),
    .mode_req (mode_req),
    .req_code (req_code),
    .req_ok   (req_ok)
  );

  state_t             state_q, state_d;
  logic [2:0]         cur_mode_q, cur_mode_d;
  logic [2:0]         target_q, target_d;
  logic [3:0]         guard_cnt_q, guard_cnt_d;
  logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
  logic               idle_seen_q, idle_seen_d;
  logic               drain_timeout_q, drain_timeout_d;
  logic [NMODES-1:0]  mode_sel_q, mode_sel_d;
  logic [NMODES-1:0]  cur_onehot;
  logic               busy_old, drain_done;
  logic [3:0]         flags_q, flags_d;

  logic               slwr_q, slwr_d, slrd_q, slrd_d, sloe_q, sloe_d;
  logic               pktend_q, pktend_d, data_oe_q, data_oe_d;
  logic [1:0]         faddr_q, faddr_d;
  logic [DW-1:0]      data_q, data_d;
  logic               m_slwr, m_slrd, m_sloe, m_pktend;
  logic [1:0]         m_faddr;
  logic [DW-1:0]      m_data;

  always_comb begin
    for (int i = 0; i < NMODES; i++) begin
      cur_onehot[i] = (cur_mode_q == 3'(i + 1));
    end
    busy_old = |(req_busy & cur_onehot);
  end

  always_comb begin
    state_d         = state_q;
    cur_mode_d      = cur_mode_q;
    target_d        = target_q;
    guard_cnt_d     = guard_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    idle_seen_d     = idle_seen_q;
    drain_timeout_d = drain_timeout_q;
    drain_done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_ok && req_code != MODE_NONE && req_code != cur_mode_q) begin
          target_d    = req_code;
          guard_cnt_d = 4'd0;
          state_d     = ST_GUARD;
        end
      end
      ST_ACTIVE: begin
        if (req_ok && req_code != cur_mode_q) begin
          target_d    = req_code;
          drain_cnt_d = '0;
          idle_seen_d = 1'b0;
          guard_cnt_d = 4'd0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        guard_cnt_d = 4'd0;
        if (req_ok) begin
          target_d = req_code;
        end
        idle_seen_d = !busy_old;
        drain_cnt_d = drain_cnt_q + DCW'(1);
        drain_done  = !busy_old && idle_seen_q;
        // The old generator is never cut off mid-burst unless it overstays.
        if (drain_done || drain_cnt_q == DCW'(DRAIN_MAX - 1)) begin
          if (!drain_done) begin
            drain_timeout_d = 1'b1;
          end
          if (target_d == MODE_NONE) begin
            state_d    = ST_IDLE;
            cur_mode_d = MODE_NONE;
          end else begin
            state_d = ST_GUARD;
          end
        end
      end
      ST_GUARD: begin
        if (req_ok) begin
          target_d = req_code;
        end
        if (guard_cnt_q == 4'(GUARD_CYC - 1)) begin
          if (target_d == MODE_NONE) begin
            state_d    = ST_IDLE;
            cur_mode_d = MODE_NONE;
          end else begin
            state_d    = ST_ACTIVE;
            cur_mode_d = target_d;
          end
        end else begin
          guard_cnt_d = guard_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    for (int i = 0; i < NMODES; i++) begin
      mode_sel_d[i] = (state_d == ST_ACTIVE) && (cur_mode_d == 3'(i + 1));
    end
  end

  // Single-source mux: cur_onehot guarantees strobes are never merged.
  always_comb begin
    m_slwr   = 1'b1;
    m_slrd   = 1'b1;
    m_sloe   = 1'b1;
    m_pktend = 1'b1;
    m_faddr  = FADDR_IDLE;
    m_data   = '0;
    if (state_q == ST_ACTIVE || state_q == ST_DRAIN) begin
      for (int i = 0; i < NMODES; i++) begin
        if (cur_onehot[i]) begin
          m_slwr   = req_slwr_n[i];
          m_slrd   = req_slrd_n[i];
          m_sloe   = req_sloe_n[i];
          m_pktend = req_pktend_n[i];
          m_faddr  = req_faddr[2*i +: 2];
          m_data   = req_data[DW*i +: DW];
        end
      end
    end
    slwr_d    = m_slwr;
    slrd_d    = m_slrd | ~m_slwr;
    sloe_d    = m_sloe;
    pktend_d  = m_pktend;
    data_oe_d = ~m_slwr | ~m_pktend;
    faddr_d   = m_faddr;
    data_d    = m_data;
    flags_d   = {flagd, flagc, flagb, flaga};
  end

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      state_q         <= ST_IDLE;
      cur_mode_q      <= MODE_NONE;
      target_q        <= MODE_NONE;
      guard_cnt_q     <= 4'd0;
      drain_cnt_q     <= '0;
      idle_seen_q     <= 1'b0;
      drain_timeout_q <= 1'b0;
      mode_sel_q      <= '0;
      flags_q         <= 4'd0;
      slwr_q          <= 1'b1;
      slrd_q          <= 1'b1;
      sloe_q          <= 1'b1;
      pktend_q        <= 1'b1;
      data_oe_q       <= 1'b0;
      faddr_q         <= FADDR_IDLE;
      data_q          <= '0;
    end else begin
      state_q         <= state_d;
      cur_mode_q      <= cur_mode_d;
      target_q        <= target_d;
      guard_cnt_q     <= guard_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      idle_seen_q     <= idle_seen_d;
      drain_timeout_q <= drain_timeout_d;
      mode_sel_q      <= mode_sel_d;
      flags_q         <= flags_d;
      slwr_q          <= slwr_d;
      slrd_q          <= slrd_d;
      sloe_q          <= sloe_d;
      pktend_q        <= pktend_d;
      data_oe_q       <= data_oe_d;
      faddr_q         <= faddr_d;
      data_q          <= data_d;
    end
  end

  assign mode_sel      = mode_sel_q;
  assign cur_mode      = cur_mode_q;
  assign drain_timeout = drain_timeout_q;
  assign {flagd_d, flagc_d, flagb_d, flaga_d} = flags_q;
  assign slwr_         = slwr_q;
  assign slrd_         = slrd_q;
  assign sloe_         = sloe_q;
  assign pktend_       = pktend_q;
  assign data_oe       = data_oe_q;
  assign faddr         = faddr_q;
  assign data_out      = data_q;

endmodule

// File: tb/tb_slavefifo2b_mode_ctrl.sv
// Scoreboard bench for slavefifo2b_mode_ctrl: expectations are queued when a
// scenario is driven and popped as the controller responds.
module tb_slavefifo2b_mode_ctrl;
  import slavefifo2b_pkg::*;

  localparam int NM = 4;
  localparam int DW = 32;

  logic            clk_100;
  logic            reset_;
  logic [2:0]      mode_req;
  logic            flaga, flagb, flagc, flagd;
  logic            flaga_d, flagb_d, flagc_d, flagd_d;
  logic [NM-1:0]   mode_sel;
  logic [NM-1:0]   req_busy, req_slwr_n, req_slrd_n, req_sloe_n, req_pktend_n;
  logic [2*NM-1:0] req_faddr;
  logic [DW*NM-1:0] req_data;
  logic            slwr_, slrd_, sloe_, pktend_;
  logic [1:0]      faddr;
  logic [DW-1:0]   data_out;
  logic            data_oe;
  logic [2:0]      cur_mode;
  logic            drain_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sbq[$];

  slavefifo2b_mode_ctrl #(.NMODES(NM), .DW(DW), .GUARD_CYC(4), .DRAIN_MAX(255)) dut (
    .clk_100(clk_100), .reset_(reset_), .mode_req(mode_req),
    .flaga(flaga), .flagb(flagb), .flagc(flagc), .flagd(flagd),
    .flaga_d(flaga_d), .flagb_d(flagb_d), .flagc_d(flagc_d), .flagd_d(flagd_d),
    .mode_sel(mode_sel), .req_busy(req_busy), .req_slwr_n(req_slwr_n),
    .req_slrd_n(req_slrd_n), .req_sloe_n(req_sloe_n), .req_pktend_n(req_pktend_n),
    .req_faddr(req_faddr), .req_data(req_data),
    .slwr_(slwr_), .slrd_(slrd_), .sloe_(sloe_), .pktend_(pktend_),
    .faddr(faddr), .data_out(data_out), .data_oe(data_oe),
    .cur_mode(cur_mode), .drain_timeout(drain_timeout)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic popCheck(input logic [63:0] obs);
    exp_t e;
    checkOutput("sb_has_entry", 64'(sbq.size() != 0), 64'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] code);
    mode_req = code;
  endtask

  task automatic setGen(input int i, input logic wr, input logic rd, input logic oe,
                        input logic pe, input logic busy, input logic [1:0] fa,
                        input logic [DW-1:0] d);
    req_slwr_n[i]        = wr;
    req_slrd_n[i]        = rd;
    req_sloe_n[i]        = oe;
    req_pktend_n[i]      = pe;
    req_busy[i]          = busy;
    req_faddr[2*i +: 2]  = fa;
    req_data[DW*i +: DW] = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  task automatic waitSel(input string tag, input logic [NM-1:0] want, input int maxc, output int n);
    n = 0;
    while (mode_sel !== want && n < maxc) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 64'(mode_sel), 64'(want));
  endtask

  function automatic logic [4:0] pinState();
    return {slwr_, slrd_, sloe_, pktend_, data_oe};
  endfunction

  function automatic logic [3:0] flagsOut();
    return {flagd_d, flagc_d, flagb_d, flaga_d};
  endfunction

  initial begin
    int n;
    reset_   = 1'b1;
    applyStimulus(MODE_NONE);
    {flagd, flagc, flagb, flaga} = 4'b1111;
    req_busy = '0; req_slwr_n = '1; req_slrd_n = '1; req_sloe_n = '1; req_pktend_n = '1;
    req_faddr = '0; req_data = '0;
    #2 reset_ = 1'b0;

    pushExp("rst_mode_sel", 0); pushExp("rst_cur_mode", 0); pushExp("rst_pins", 5'b11110);
    pushExp("rst_faddr", 0); pushExp("rst_data", 0); pushExp("rst_flags", 0); pushExp("rst_timeout", 0);
    tick(3);
    popCheck(64'(mode_sel)); popCheck(64'(cur_mode)); popCheck(64'(pinState()));
    popCheck(64'(faddr)); popCheck(64'(data_out)); popCheck(64'(flagsOut())); popCheck(64'(drain_timeout));
    reset_ = 1'b1;

    // ZLP grant from IDLE; its early write must stay off the pins until granted
    setGen(3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 32'hDEAD_0004);
    applyStimulus(MODE_ZLP);
    pushExp("s1_mode_sel", 4'b1000); pushExp("s1_cur_mode", 4); pushExp("s1_pins_at_grant", 5'b11110);
    pushExp("s1_slwr", 0); pushExp("s1_data_oe", 1); pushExp("s1_faddr", 2);
    pushExp("s1_data", 32'hDEAD_0004); pushExp("s1_latency_ok", 1);
    n = 0;
    while (mode_sel == '0 && n < 40) begin
      checkOutput("s1_guard_pins", 64'(pinState()), 64'b11110);
      tick(1);
      n++;
    end
    popCheck(64'(mode_sel)); popCheck(64'(cur_mode)); popCheck(64'(pinState()));
    tick(1);
    popCheck(64'(slwr_)); popCheck(64'(data_oe)); popCheck(64'(faddr)); popCheck(64'(data_out));
    popCheck(64'(n >= 8 && n <= 12));

    {flagd, flagc, flagb, flaga} = 4'b0101; pushExp("flags_0101", 4'b0101);
    tick(1); popCheck(64'(flagsOut()));
    {flagd, flagc, flagb, flaga} = 4'b1010; pushExp("flags_1010", 4'b1010);
    tick(1); popCheck(64'(flagsOut()));

    // Switch to STREAM_IN, then read traffic from generator 2
    setGen(3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, '0);
    applyStimulus(MODE_STREAM_IN);
    waitSel("s2_grant2", 4'b0010, 40, n);
    setGen(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h1111_0002);
    pushExp("s2_rd_pins", 5'b10010); pushExp("s2_rd_faddr", 1);
    tick(1); popCheck(64'(pinState())); popCheck(64'(faddr));

    // Short glitch to STREAM_OUT must not cause a switch
    applyStimulus(MODE_STREAM_OUT);
    tick(2);
    applyStimulus(MODE_STREAM_IN);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      checkOutput("s4_no_switch_sel", 64'(mode_sel), 64'b0010);
    end
    pushExp("s4_cur_mode", 2); popCheck(64'(cur_mode));

    // Generator drives both strobes: write wins, read forced high
    setGen(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h1111_0002);
    pushExp("s2_wr_wins", 5'b01011);
    tick(1); popCheck(64'(pinState()));

    // Switch to STREAM_OUT while generator 2 stays busy for 20 cycles
    setGen(2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'h3333_0003);
    applyStimulus(MODE_STREAM_OUT);
    waitSel("s2_deselect", 4'b0000, 20, n);
    pushExp("s2_cur_during_drain", 2); popCheck(64'(cur_mode));
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checkOutput("s2_drain_follow", 64'(pinState()), 64'b01011);
      checkOutput("s2_drain_sel", 64'(mode_sel), 64'd0);
    end
    setGen(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 32'h1111_0002);
    tick(1);
    checkOutput("s2_drain_faddr", 64'(faddr), 64'd3);
    setGen(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, '0);
    pushExp("s2_grant_delay", 6); pushExp("s2_sel3", 4'b0100); pushExp("s2_pins_at_grant", 5'b11110);
    pushExp("s2_slwr3", 0); pushExp("s2_faddr3", 2);
    n = 0;
    while (mode_sel == '0 && n < 20) begin
      tick(1);
      n++;
      if (mode_sel == '0) checkOutput("s2_guard_pins", 64'(pinState()), 64'b11110);
    end
    popCheck(64'(n)); popCheck(64'(mode_sel)); popCheck(64'(pinState()));
    tick(1);
    popCheck(64'(slwr_)); popCheck(64'(faddr));

    // Generator 3 never goes idle: forced switch after the drain limit
    setGen(2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 32'h3333_0003);
    applyStimulus(MODE_LOOPBACK);
    waitSel("s3_deselect", 4'b0000, 20, n);
    pushExp("s3_timeout_cyc", 255); pushExp("s3_grant_cyc", 259); pushExp("s3_sel1", 4'b0001);
    pushExp("s3_timeout_sticky", 1);
    n = 0;
    while (drain_timeout == 1'b0 && n < 300) begin
      tick(1);
      n++;
    end
    popCheck(64'(n));
    while (mode_sel == '0 && n < 320) begin
      tick(1);
      n++;
    end
    popCheck(64'(n)); popCheck(64'(mode_sel));
    setGen(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, '0);
    tick(5);
    popCheck(64'(drain_timeout));

    // Out-of-range code while writing acts as "no mode": back to IDLE
    setGen(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0001);
    pushExp("s5_active_wr", 5'b01111);
    tick(1); popCheck(64'(pinState()));
    applyStimulus(3'd7);
    pushExp("s5_cur_idle", 0); pushExp("s5_pins_idle", 5'b11110); pushExp("s5_sel_idle", 0);
    pushExp("s5_stay_idle", 0);
    n = 0;
    while (cur_mode != 3'd0 && n < 30) begin
      tick(1);
      n++;
    end
    popCheck(64'(cur_mode));
    tick(1);
    popCheck(64'(pinState())); popCheck(64'(mode_sel));
    tick(10);
    popCheck(64'(cur_mode));

    applyStimulus(MODE_LOOPBACK);
    waitSel("s5_regrant", 4'b0001, 40, n);
    applyStimulus(MODE_NONE);
    pushExp("s5b_cur_idle", 0); pushExp("s5b_pins_idle", 5'b11110);
    n = 0;
    while (cur_mode != 3'd0 && n < 30) begin
      tick(1);
      n++;
    end
    popCheck(64'(cur_mode));
    tick(1);
    popCheck(64'(pinState()));

    // Asynchronous reset in the middle of a write burst
    applyStimulus(MODE_LOOPBACK);
    waitSel("s6_grant", 4'b0001, 40, n);
    {flagd, flagc, flagb, flaga} = 4'b1111;
    tick(2);
    pushExp("s6_burst_slwr", 0); pushExp("s6_flags_on", 4'b1111);
    popCheck(64'(slwr_)); popCheck(64'(flagsOut()));
    pushExp("s6_rst_slwr", 1); pushExp("s6_rst_sel", 0); pushExp("s6_rst_flags", 0);
    pushExp("s6_rst_oe", 0); pushExp("s6_rst_cur", 0);
    #2 reset_ = 1'b0;
    #1;
    popCheck(64'(slwr_)); popCheck(64'(mode_sel)); popCheck(64'(flagsOut()));
    popCheck(64'(data_oe)); popCheck(64'(cur_mode));
    tick(1);
    reset_ = 1'b1;
    waitSel("s6_regrant", 4'b0001, 40, n);
    pushExp("s6_timeout_cleared", 0); popCheck(64'(drain_timeout));

    checkOutput("sb_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
